// File: rtl/pc_select_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_select_reg_pkg
// Purpose : Shared definitions for the next-PC selector and its decode users.
//           Holds the reset vector and increment defaults, the symbolic
//           redirect-source indices (lower index = higher priority) and a
//           helper that sizes source-index fields.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package pc_select_reg_pkg;

  localparam logic [31:0] C_RESET_VEC = 32'h0000_0000;
  localparam int          C_INCR      = 4;

  // Redirect source indices, highest priority first.
  localparam int C_SRC_TRAP   = 0;
  localparam int C_SRC_JUMP   = 1;
  localparam int C_SRC_BRANCH = 2;
  localparam int C_SRC_PRED   = 3;

  // Width of a field able to hold any index 0..n-1; never narrower than 1.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : pc_select_reg_pkg
`default_nettype wire

// File: rtl/pc_select_reg_prio_enc_lsb.sv
`default_nettype none
// ============================================================================
// Module  : prio_enc_lsb
// Purpose : Lowest-set-bit priority encoder. Bit 0 has the highest priority.
// Ports   : req [N-1:0]  in   request vector
//           idx [SW-1:0] out  index of the lowest set bit (0 when none set)
//           any          out  at least one request bit is set
// Revision: 1.0 - initial release
// ============================================================================
module prio_enc_lsb #(
  parameter int N  = 4,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [SW-1:0] idx,
  output logic          any
);

  // Scan from the top so the lowest set bit is the last (winning) assignment.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = SW'(i);
    end
  end

  assign any = |req;

endmodule : prio_enc_lsb
`default_nettype wire

// File: rtl/pc_select_reg.sv
`default_nettype none
// ============================================================================
// Module  : pc_select_reg
// Purpose : Registered N-source next-PC selector for instruction fetch.
//           Fixed-priority redirect arbitration (source 0 highest), a
//           sequential increment path, stall hold and a one-entry pending
//           redirect buffer that captures redirects arriving during stall.
// Ports   : clk        in   rising-edge clock
//           rst_n      in   asynchronous active-low reset
//           stall      in   hold pc_q; redirects seen now are buffered
//           src_valid  in   per-source redirect request [N_SRC]
//           src_data   in   packed targets, source i at [i*WIDTH +: WIDTH]
//           pc_q       out  registered current PC
//           redirect_q out  pc_q came from a redirect on the last update
//           sel_q      out  index of the source that produced pc_q
//           pending_q  out  a buffered redirect waits for stall to drop
//           misalign_q out  pc_q[1:0] != 0
// Revision: 1.0 - initial release
// ============================================================================
module pc_select_reg
  import pc_select_reg_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               N_SRC     = 4,
  parameter int               INCR      = C_INCR,
  parameter logic [WIDTH-1:0] RESET_VEC = C_RESET_VEC
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic [N_SRC-1:0]               src_valid,
  input  logic [N_SRC*WIDTH-1:0]         src_data,
  output logic [WIDTH-1:0]               pc_q,
  output logic                           redirect_q,
  output logic [sel_width(N_SRC)-1:0]    sel_q,
  output logic                           pending_q,
  output logic                           misalign_q
);

  localparam int SW = sel_width(N_SRC);

  logic [WIDTH-1:0] w_lane [N_SRC];
  logic [SW-1:0]    w_win_idx;
  logic             w_any;
  logic [WIDTH-1:0] w_win_data;
  logic             w_take_live;

  logic [WIDTH-1:0] w_pc_next;
  logic [SW-1:0]    w_sel_next;
  logic             w_redir_next;

  logic [WIDTH-1:0] r_pc;
  logic [SW-1:0]    r_sel;
  logic             r_redir;
  logic             r_misalign;
  logic             r_pending;
  logic [WIDTH-1:0] r_pend_data;
  logic [SW-1:0]    r_pend_idx;

  prio_enc_lsb #(
    .N  (N_SRC),
    .SW (SW)
  ) u_prio (
    .req (src_valid),
    .idx (w_win_idx),
    .any (w_any)
  );

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_lane
    assign w_lane[gi] = src_data[gi*WIDTH +: WIDTH];
  end

  // Masked so an idle request vector never lets undriven lane data through.
  assign w_win_data = w_any ? w_lane[w_win_idx] : '0;

  // A live request beats the buffered one when it is of equal or higher
  // priority; on a tie the newest target from that source is used.
  assign w_take_live = w_any && (!r_pending || (w_win_idx <= r_pend_idx));

  always_comb begin
    w_pc_next    = r_pc + WIDTH'(INCR);
    w_sel_next   = r_sel;
    w_redir_next = 1'b0;
    if (w_take_live) begin
      w_pc_next    = w_win_data;
      w_sel_next   = w_win_idx;
      w_redir_next = 1'b1;
    end else if (r_pending) begin
      w_pc_next    = r_pend_data;
      w_sel_next   = r_pend_idx;
      w_redir_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_VEC;
      r_sel       <= '0;
      r_redir     <= 1'b0;
      r_misalign  <= |RESET_VEC[1:0];
      r_pending   <= 1'b0;
      r_pend_data <= '0;
      r_pend_idx  <= '0;
    end else if (stall) begin
      if (w_take_live) begin
        r_pend_data <= w_win_data;
        r_pend_idx  <= w_win_idx;
        r_pending   <= 1'b1;
      end
    end else begin
      r_pc       <= w_pc_next;
      r_sel      <= w_sel_next;
      r_redir    <= w_redir_next;
      r_misalign <= |w_pc_next[1:0];
      r_pending  <= 1'b0;
    end
  end

  assign pc_q       = r_pc;
  assign redirect_q = r_redir;
  assign sel_q      = r_sel;
  assign pending_q  = r_pending;
  assign misalign_q = r_misalign;

endmodule : pc_select_reg
`default_nettype wire

// File: tb/tb_pc_select_reg.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_select_reg
// Purpose : Self-checking bench for pc_select_reg (WIDTH=32, N_SRC=4).
//           Directed vectors; a behavioural next-PC model checked every
//           cycle plus literal expectations at key points.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pc_select_reg;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stall = 1'b0;
  logic [3:0]   src_valid = '0;
  logic [127:0] src_data = '0;
  logic [31:0]  pc_q;
  logic         redirect_q;
  logic [1:0]   sel_q;
  logic         pending_q;
  logic         misalign_q;

  int errors = 0;
  int checks = 0;

  pc_select_reg #(
    .WIDTH     (32),
    .N_SRC     (4),
    .INCR      (4),
    .RESET_VEC (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .pc_q       (pc_q),
    .redirect_q (redirect_q),
    .sel_q      (sel_q),
    .pending_q  (pending_q),
    .misalign_q (misalign_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the architectural state written as plain variables.
  logic [31:0] m_pc = 32'h0;
  logic        m_redir = 1'b0;
  int          m_sel = 0;
  logic        m_pend = 1'b0;
  logic [31:0] m_pdata = 32'h0;
  int          m_pidx = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_redir = 1'b0; m_sel = 0; m_pend = 1'b0;
      m_pdata = 32'h0; m_pidx = 0;
    end else begin
      int win;
      logic [31:0] tgt;
      win = -1;
      for (int i = 3; i >= 0; i--) if (src_valid[i]) win = i;
      tgt = (win >= 0) ? src_data[win*32 +: 32] : 32'h0;
      if (stall) begin
        if (win >= 0 && (!m_pend || win <= m_pidx)) begin
          m_pdata = tgt; m_pidx = win; m_pend = 1'b1;
        end
      end else begin
        if (win >= 0 && (!m_pend || win <= m_pidx)) begin
          m_pc = tgt; m_sel = win; m_redir = 1'b1;
        end else if (m_pend) begin
          m_pc = m_pdata; m_sel = m_pidx; m_redir = 1'b1;
        end else begin
          m_pc = m_pc + 32'd4; m_redir = 1'b0;
        end
        m_pend = 1'b0;
      end
    end
  end

  logic run_cmp = 1'b0;
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("model_pc", pc_q, m_pc);
      chk("model_redirect", {31'b0, redirect_q}, {31'b0, m_redir});
      chk("model_sel", {30'b0, sel_q}, 32'(m_sel));
      chk("model_pending", {31'b0, pending_q}, {31'b0, m_pend});
      chk("model_misalign", {31'b0, misalign_q}, {31'b0, |m_pc[1:0]});
    end
  end

  // Apply one cycle of inputs at the falling edge and return at the next one.
  task automatic cyc(input logic st, input logic [3:0] v,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input logic [31:0] d2, input logic [31:0] d3);
    stall = st;
    src_valid = v;
    src_data = {d3, d2, d1, d0};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 4'b0000, 32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003);
  endtask

  localparam logic [31:0] G = 32'hBAD0_0001;

  initial begin
    repeat (2) @(negedge clk);
    run_cmp = 1'b1;
    chk("rst_pc", pc_q, 32'h0);
    chk("rst_redirect", {31'b0, redirect_q}, 32'h0);
    chk("rst_sel", {30'b0, sel_q}, 32'h0);
    chk("rst_pending", {31'b0, pending_q}, 32'h0);
    chk("rst_misalign", {31'b0, misalign_q}, 32'h0);

    rst_n = 1'b1;
    idle(); chk("inc1", pc_q, 32'd4);
    idle(); chk("inc2", pc_q, 32'd8);
    idle(); chk("inc3", pc_q, 32'd12);

    // Priority: source 1 beats source 2.
    cyc(1'b0, 4'b0110, G, 32'h100, 32'h200, G);
    chk("prio_pc", pc_q, 32'h100);
    chk("prio_sel", {30'b0, sel_q}, 32'd1);
    chk("prio_redir", {31'b0, redirect_q}, 32'd1);

    // Stall buffer then release.
    cyc(1'b1, 4'b0100, G, G, 32'h200, G);
    chk("stall_hold_pc", pc_q, 32'h100);
    chk("stall_pending", {31'b0, pending_q}, 32'd1);
    idle();
    chk("drain_pc", pc_q, 32'h200);
    chk("drain_sel", {30'b0, sel_q}, 32'd2);
    chk("drain_pending", {31'b0, pending_q}, 32'd0);
    idle();
    chk("post_drain_inc", pc_q, 32'h204);

    // Pre-emption by higher-priority live request.
    cyc(1'b1, 4'b0100, G, G, 32'h200, G);
    cyc(1'b0, 4'b0001, 32'h80, G, G, G);
    chk("preempt_pc", pc_q, 32'h80);
    chk("preempt_sel", {30'b0, sel_q}, 32'd0);
    chk("preempt_pending", {31'b0, pending_q}, 32'd0);
    idle();

    // Lower-priority live request loses to the buffered one.
    cyc(1'b1, 4'b0100, G, G, 32'h200, G);
    cyc(1'b0, 4'b1000, G, G, G, 32'h300);
    chk("lowprio_pc", pc_q, 32'h200);
    chk("lowprio_sel", {30'b0, sel_q}, 32'd2);
    idle();

    // Tie: same source newest target wins; lower priority never displaces.
    cyc(1'b1, 4'b0100, G, G, 32'h240, G);
    cyc(1'b1, 4'b1000, G, G, G, 32'h300);
    cyc(1'b0, 4'b0100, G, G, 32'h280, G);
    chk("tie_pc", pc_q, 32'h280);

    // Higher priority replaces buffered entry during stall.
    cyc(1'b1, 4'b0100, G, G, 32'h200, G);
    cyc(1'b1, 4'b0010, G, 32'h180, G, G);
    idle();
    chk("displace_pc", pc_q, 32'h180);
    chk("displace_sel", {30'b0, sel_q}, 32'd1);

    // Wrap-around and misalignment.
    cyc(1'b0, 4'b0001, 32'hFFFF_FFFC, G, G, G);
    chk("wrap_pre", pc_q, 32'hFFFF_FFFC);
    idle();
    chk("wrap_pc", pc_q, 32'h0);
    chk("wrap_redir", {31'b0, redirect_q}, 32'd0);
    cyc(1'b0, 4'b0010, G, 32'h102, G, G);
    chk("mis_pc", pc_q, 32'h102);
    chk("mis_flag", {31'b0, misalign_q}, 32'd1);
    idle();
    chk("mis_inc", pc_q, 32'h106);

    // Asynchronous reset while a redirect is buffered.
    cyc(1'b1, 4'b0100, G, G, 32'h200, G);
    chk("pre_rst_pending", {31'b0, pending_q}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc_q, 32'h0);
    chk("arst_pending", {31'b0, pending_q}, 32'd0);
    chk("arst_redir", {31'b0, redirect_q}, 32'd0);
    stall = 1'b0;
    src_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("arst_release_pc", pc_q, 32'd4);
    chk("arst_release_redir", {31'b0, redirect_q}, 32'd0);

    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pc_select_reg
`default_nettype wire
